// File: rtl/sme_pkg.sv
// sme_pkg: shared character codes, framer state encoding and length-width helper
package sme_pkg;
    localparam logic [7:0] CHAR_NL     = 8'h0A;
    localparam logic [7:0] CHAR_CARET  = 8'h5E;
    localparam logic [7:0] CHAR_DOLLAR = 8'h24;
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] COLLECT_STR = 3'd1;
    localparam logic [2:0] COLLECT_PAT = 3'd2;
    localparam logic [2:0] SEND_STR    = 3'd3;
    localparam logic [2:0] SEND_PAT    = 3'd4;
    localparam logic [2:0] WAIT_RES    = 3'd5;
    function automatic int len_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sme_char_buf.sv
// sme_char_buf: character buffer with append-only write index and sequential read index
module sme_char_buf
    import sme_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     wr,
    input  logic [7:0]               din,
    input  logic                     rd,
    output logic [7:0]               dout,
    output logic [len_w(DEPTH)-1:0]  len,
    output logic                     full,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = len_w(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    logic [7:0]    mem [DEPTH];
    logic [LW-1:0] rd_idx;
    always_ff @(posedge clk)
        if (wr && !full) mem[len[AW-1:0]] <= din;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            len    <= '0;
            rd_idx <= '0;
        end else if (clr) begin
            len    <= '0;
            rd_idx <= '0;
        end else begin
            if (wr && !full) len <= len + 1'b1;
            if (rd) rd_idx <= rd_idx + 1'b1;
        end
    assign dout = mem[rd_idx[AW-1:0]];
    assign full = len == DEPTH_L;
    assign done = rd_idx == len;
endmodule

// File: rtl/sme_input_framer.sv
// sme_input_framer: buffers "<string>\n<pattern>\n" host records and replays them to the SME.
// Optional WAIT_RES timeout enabled by defining SME_FRAMER_TIMEOUT_EN.
module sme_input_framer
    import sme_pkg::*;
#(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8
`ifdef SME_FRAMER_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    output logic       busy,
    output logic       err
);
    localparam int SLW = len_w(STR_MAX);
    localparam int PLW = len_w(PAT_MAX);
    logic [2:0]     state, nxt;
    logic           acc, nl, term, drop, clr, ovf, err_n, have_str, trunc, tmo;
    logic           str_wr, pat_wr, str_rd, pat_rd, str_full, pat_full, str_done, pat_done;
    logic [7:0]     str_dout, pat_dout;
    logic [SLW-1:0] str_len;
    logic [PLW-1:0] pat_len;
    assign acc    = in_valid && in_ready;
    assign nl     = in_data == CHAR_NL;
    assign term   = acc && nl && state == COLLECT_PAT;
    // An empty string field is only usable if the SME already holds a string
    assign drop   = pat_len == '0 || (str_len == '0 && !have_str);
    assign str_wr = acc && !nl && (state == IDLE || state == COLLECT_STR);
    assign pat_wr = acc && !nl && state == COLLECT_PAT;
    assign ovf    = (str_wr && str_full) || (pat_wr && pat_full);
    assign str_rd = (term && !drop && str_len != '0) || (state == SEND_STR && !str_done);
    assign pat_rd = (term && !drop && str_len == '0) || (state == SEND_STR && str_done) ||
                    (state == SEND_PAT && !pat_done);
    assign clr    = nxt == IDLE && state != IDLE;
    assign err_n  = (term && drop) || (state == WAIT_RES && nxt == IDLE && (trunc || tmo));
`ifdef SME_FRAMER_TIMEOUT_EN
    logic [7:0] wcnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) wcnt <= '0;
        else wcnt <= state == WAIT_RES ? wcnt + 8'd1 : 8'd0;
    assign tmo = state == WAIT_RES && !sme_valid && wcnt == 8'(TIMEOUT - 1);
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:        if (acc) nxt = nl ? COLLECT_PAT : COLLECT_STR;
            COLLECT_STR: if (acc && nl) nxt = COLLECT_PAT;
            COLLECT_PAT: if (term) nxt = drop ? IDLE : str_len != '0 ? SEND_STR : SEND_PAT;
            SEND_STR:    if (str_done) nxt = SEND_PAT;
            SEND_PAT:    if (pat_done) nxt = WAIT_RES;
            WAIT_RES:    if (sme_valid || tmo) nxt = IDLE;
            default:     nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            chardata  <= '0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            have_str  <= 1'b0;
            trunc     <= 1'b0;
        end else begin
            state     <= nxt;
            chardata  <= str_rd ? str_dout : pat_rd ? pat_dout : 8'h00;
            isstring  <= str_rd;
            ispattern <= pat_rd;
            busy      <= nxt >= SEND_STR;
            in_ready  <= nxt < SEND_STR;
            err       <= err_n;
            have_str  <= tmo ? 1'b0 : (state == SEND_STR && str_done) ? 1'b1 : have_str;
            trunc     <= clr ? 1'b0 : trunc | ovf;
        end
    sme_char_buf #(.DEPTH(STR_MAX)) u_str (
        .clk(clk), .reset(reset), .clr(clr), .wr(str_wr), .din(in_data), .rd(str_rd),
        .dout(str_dout), .len(str_len), .full(str_full), .done(str_done)
    );
    sme_char_buf #(.DEPTH(PAT_MAX)) u_pat (
        .clk(clk), .reset(reset), .clr(clr), .wr(pat_wr), .din(in_data), .rd(pat_rd),
        .dout(pat_dout), .len(pat_len), .full(pat_full), .done(pat_done)
    );
endmodule
